pmem_responder: RTL
===================

Name: pmem_responder

Overview:
- Line-granular physical-memory responder on the pmem side of the cache: accepts pmem_read/pmem_write line requests, services them after a fixed latency, and pulses pmem_resp.
- Provides a synthesizable backing store and timing model for cache bring-up and verification.
- Includes saturating read/write counters for bench checking.

Parameters:
s_offset, 5, byte-offset bits within a line (line = 2**s_offset bytes)
s_line, 256, line width in bits (8*2**s_offset)
s_depth, 8, index bits; array holds 2**s_depth lines
LATENCY, 10, BUSY cycles before response; legal range 1..255

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
pmem_address  input  32  byte address of line; bits [s_offset-1:0] ignored
pmem_wdata  input  s_line  write line data
pmem_read  input  1  read request, held by initiator until pmem_resp
pmem_write  input  1  write request, held by initiator until pmem_resp
pmem_rdata  output  s_line  read line data, valid in pmem_resp cycle, held until next read completes
pmem_resp  output  1  one-cycle completion pulse
busy  output  1  high in BUSY and RESP
rd_count  output  16  completed reads, saturates at 16'hFFFF
wr_count  output  16  completed writes, saturates at 16'hFFFF

Behaviour:
- Reset (rst=0, async): state IDLE; pmem_resp=0, busy=0, pmem_rdata=0, rd_count=0, wr_count=0, latency counter=0.
  - Array contents are not reset.
  - Reset mid-operation aborts the operation. A write not yet committed is not performed.
- Index: pmem_address[s_offset +: s_depth]. Upper address bits are ignored, so addresses alias modulo 2**s_depth lines.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: if pmem_read|pmem_write, latch index, wdata and op; load counter=LATENCY-1; go BUSY. Otherwise stay in IDLE.
  - BUSY: if counter==0, perform the access and go RESP. Otherwise decrement the counter.
    - Write: array[index] <= latched wdata.
    - Read: pmem_rdata <= array[index].
  - RESP: pmem_resp=1 for exactly this cycle; increment the matching counter (saturating); go IDLE.
- Latency: the request is first high in IDLE at cycle 0. pmem_resp is high in cycle LATENCY+1. The next request can be accepted in cycle LATENCY+2.
  - The initiator deasserts its request in the cycle after pmem_resp. Back-to-back requests therefore start at cycle LATENCY+2.
- Address, wdata and op are sampled only at acceptance. Changes during BUSY/RESP are ignored.
- Simultaneous pmem_read and pmem_write at acceptance: treated as a write; rd_count is unchanged.
- Request dropped during BUSY (protocol violation): the operation still completes and pmem_resp still pulses.
- Read-after-write to the same line returns the newly written data, since the write commits before RESP.
- pmem_rdata is unchanged by writes and by idle cycles.

Test Plan:
- Reset, then write 0xAAAA...AAAA to 0x0000_0040 at LATENCY=10 -> pmem_resp high only in cycle 11; wr_count=1; busy high cycles 1-11.
- Read 0x0000_0040 after that write -> pmem_rdata=0xAAAA...AAAA in the pmem_resp cycle (cycle 11); rd_count=1; rdata held through later idle cycles.
- Alias check: write 0x1234...0 to 0x0000_2040 (s_depth=8), then read 0x0000_0040 -> returns 0x1234...0. Also address 0x0000_005F maps to the same line as 0x0000_0040.
- Both read and write high with wdata=0x5555...5555, address changed to 0x80 mid-BUSY -> line at the original address holds 0x55..55; wr_count increments; rd_count unchanged; line 0x80 untouched.
- Assert rst=0 in BUSY cycle 5 of a write -> outputs zero immediately without waiting for clk; no pmem_resp; subsequent read of that line returns the old contents.
- LATENCY=1, back-to-back reads of 0x00 and 0x20 -> pmem_resp in cycles 2 and 5; rd_count=2. Force rd_count to 0xFFFF, do one more read -> stays 0xFFFF.

Source files
------------

// File: rtl/pmem_responder_if.sv
// Line-granular pmem request/response bundle between a cache (master) and
// the backing-store responder (slave).
interface pmem_responder_if #(
  parameter int s_line = 256
);
  logic [31:0]       pmem_address;
  logic [s_line-1:0] pmem_wdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              busy;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;

  modport master (
    output pmem_address, pmem_wdata, pmem_read, pmem_write,
    input  pmem_rdata, pmem_resp, busy, rd_count, wr_count
  );
  modport slave (
    input  pmem_address, pmem_wdata, pmem_read, pmem_write,
    output pmem_rdata, pmem_resp, busy, rd_count, wr_count
  );
endinterface

// File: rtl/pmem_responder.sv
// Fixed-latency line responder with a synthesizable backing array and
// saturating completion counters for bring-up benches.
module pmem_responder #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_depth  = 8,
  parameter int LATENCY  = 10
) (
  input  logic            clk,
  input  logic            rst,
  pmem_responder_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [7:0] LAT_M1  = 8'(LATENCY - 1);

  logic [1:0]         r_state;
  logic [7:0]         r_cnt;
  logic [s_depth-1:0] r_idx;
  logic [s_line-1:0]  r_wdata;
  logic               r_op_wr;
  logic [s_line-1:0]  r_rdata;
  logic [15:0]        r_rd_count;
  logic [15:0]        r_wr_count;
  logic [s_line-1:0]  r_mem [2**s_depth];

  logic w_req;
  logic w_fire;
  logic w_unused;

  assign w_req    = bus.pmem_read | bus.pmem_write;
  assign w_fire   = (r_state == ST_BUSY) && (r_cnt == 8'd0);
  assign w_unused = &{1'b0, bus.pmem_address[31:s_offset+s_depth],
                      bus.pmem_address[s_offset-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_op_wr    <= 1'b0;
      r_rdata    <= '0;
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_req) begin
          // write wins when both strobes are high
          r_idx   <= bus.pmem_address[s_offset +: s_depth];
          r_wdata <= bus.pmem_wdata;
          r_op_wr <= bus.pmem_write;
          r_cnt   <= LAT_M1;
          r_state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (w_fire) begin
            if (!r_op_wr) r_rdata <= r_mem[r_idx];
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_RESP: begin
          if (r_op_wr) begin
            if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
          end else begin
            if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Array has no reset; a reset forces IDLE so an uncommitted write is dropped.
  always_ff @(posedge clk) begin
    if (w_fire && r_op_wr) r_mem[r_idx] <= r_wdata;
  end

  assign bus.pmem_rdata = r_rdata;
  assign bus.pmem_resp  = (r_state == ST_RESP);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.rd_count   = r_rd_count;
  assign bus.wr_count   = r_wr_count;
endmodule
